// File: rtl/icache_fetch_unit.sv
// Instruction fetch stage with a direct-mapped I-cache.
// The cache holds 2**IDX_W lines of 2**OFF_W words each.
// On a hit it presents one instruction per cycle. On a miss it refills the whole line,
// one word for each mc_valid pulse.
module icache_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                IDX_W    = 6,
    parameter int                OFF_W    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              inval,
    output logic              mc_req,
    output logic [ADDR_W-1:0] mc_addr,
    input  logic              mc_valid,
    input  logic [INST_W-1:0] mc_data,
    input  logic              id_stall,
    output logic              id_valid,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc
);

    localparam int LINES  = 2**IDX_W;
    localparam int WORDS  = 2**OFF_W;
    localparam int LINE_W = ADDR_W - OFF_W - 2;
    localparam int TAG_W  = LINE_W - IDX_W;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] pc;
    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;

    // Line address ({tag, idx}) of the line being refilled.
    logic [LINE_W-1:0] fill_line;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic [OFF_W-1:0]  cnt;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [INST_W-1:0] data [LINES*WORDS];

    logic hit, fire, start_refill, word_ret, last_ret;

    assign off       = pc[OFF_W+1:2];
    assign idx       = pc[IDX_W+OFF_W+1:OFF_W+2];
    assign tag       = pc[ADDR_W-1:IDX_W+OFF_W+2];
    assign fill_idx  = fill_line[IDX_W-1:0];
    assign fill_tag  = fill_line[LINE_W-1:IDX_W];

    assign hit          = valid[idx] && (tags[idx] == tag);
    assign start_refill = (state == IDLE) && !hit && !redirect && !inval;
    assign word_ret     = (state == REFILL) && mc_valid;
    assign last_ret     = word_ret && (&cnt);
    assign fire         = id_valid && !id_stall;

    // State register; rdy low freezes the FSM.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (rdy)
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_refill) state_next = REFILL;
            REFILL:  if (last_ret)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Dispatcher outputs.
    // Nothing is offered while frozen or held in reset.
    always_comb begin
        id_valid = !rst && rdy && (state == IDLE) && hit && !redirect && !inval;
        id_inst  = data[{idx, off}];
        id_pc    = pc;
    end

    // PC, valid bits and the refill request/address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            valid     <= '0;
            cnt       <= '0;
            mc_req    <= 1'b0;
            mc_addr   <= '0;
            fill_line <= '0;
        end else if (rdy) begin
            if (redirect)
                pc <= redirect_pc;
            else if (fire)
                pc <= pc + ADDR_W'(4);

            // The set for the completing line comes after the global clear.
            // A line that finishes on the same cycle as inval therefore stays valid.
            if (inval)
                valid <= '0;
            if (last_ret)
                valid[fill_idx] <= 1'b1;

            if (start_refill) begin
                fill_line <= {tag, idx};
                cnt       <= '0;
                mc_req    <= 1'b1;
                mc_addr   <= {tag, idx, {(OFF_W+2){1'b0}}};
            end else if (word_ret) begin
                cnt     <= cnt + 1'b1;
                mc_addr <= mc_addr + ADDR_W'(4);
                if (last_ret)
                    mc_req <= 1'b0;
            end
        end
    end

    // Cache data and tag arrays.
    // They need no reset because the valid bits qualify every read.
    always_ff @(posedge clk) begin
        if (!rst && rdy && word_ret) begin
            data[{fill_idx, cnt}] <= mc_data;
            if (last_ret)
                tags[fill_idx] <= fill_tag;
        end
    end

endmodule
